// File: rtl/riscv_pipe_cpu.sv
// 5-stage in-order RV32 integer core with internal instruction/data memories and register file.
// Optional PERF_CNT_EN adds stall/flush event counters as outputs.
module riscv_pipe_cpu #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int unsigned IA_W = $clog2(IMEM_WORDS);
  localparam int unsigned DA_W = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
  } alu_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        use_imm;
    alu_op_t     alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wb_data;
  } mem_wb_t;

  logic [31:0] instr_mem [IMEM_WORDS];
  logic [31:0] data_mem  [DMEM_WORDS];
  logic [31:0] regfile   [32];

  logic [31:0] pc;
  if_id_t      if_id;
  id_ex_t      id_ex, dec;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;

  logic        stall, flush, is_beq;
  logic [31:0] rd1, rd2, imm_i, imm_s, imm_b, target;
  logic [31:0] fwd_a, fwd_b, op_b, alu_res, mem_rdata, wb_data;

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;

  assign opc = if_id.instr[6:0];
  assign rd  = if_id.instr[11:7];
  assign f3  = if_id.instr[14:12];
  assign rs1 = if_id.instr[19:15];
  assign rs2 = if_id.instr[24:20];
  assign f7  = if_id.instr[31:25];

  assign imm_i = {{20{if_id.instr[31]}}, if_id.instr[31:20]};
  assign imm_s = {{20{if_id.instr[31]}}, if_id.instr[31:25], if_id.instr[11:7]};
  assign imm_b = {{19{if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
                  if_id.instr[30:25], if_id.instr[11:8], 1'b0};
  assign target = if_id.pc + imm_b;

  // Register read with write-through from the WB stage
  always_comb begin
    rd1 = regfile[rs1];
    rd2 = regfile[rs2];
    if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == rs1) rd1 = wb_data;
    if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == rs2) rd2 = wb_data;
    if (rs1 == 5'd0) rd1 = '0;
    if (rs2 == 5'd0) rd2 = '0;
  end

  // Decode; anything unrecognised leaves every control deasserted
  always_comb begin
    dec    = '0;
    is_beq = 1'b0;
    case (opc)
      OP_R: begin
        dec.reg_write = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b111}: dec.alu_op = ALU_AND;
          {7'b0000000, 3'b100}: dec.alu_op = ALU_XOR;
          {7'b0000000, 3'b001}: dec.alu_op = ALU_SLL;
          {7'b0000000, 3'b000}: dec.alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: dec.alu_op = ALU_SUB;
          {7'b0000001, 3'b000}: dec.alu_op = ALU_MUL;
          default:              dec.reg_write = 1'b0;
        endcase
      end
      OP_I: begin
        dec.imm = imm_i;
        if (f3 == 3'b000) begin
          dec.reg_write = 1'b1;
          dec.use_imm   = 1'b1;
        end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
          dec.reg_write = 1'b1;
          dec.use_imm   = 1'b1;
          dec.alu_op    = ALU_SRA;
        end
      end
      OP_LD: if (f3 == 3'b010) begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_i;
      end
      OP_ST: if (f3 == 3'b010) begin
        dec.mem_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_s;
      end
      OP_BR: is_beq = (f3 == 3'b000);
      default: ;
    endcase
    if (dec.reg_write || dec.mem_write) begin
      dec.rs1 = rs1;
      dec.rs2 = rs2;
      dec.a   = rd1;
      dec.b   = rd2;
    end
    if (dec.reg_write) dec.rd = rd;
    if (!(dec.reg_write || dec.mem_write)) dec.imm = '0;
  end

  assign stall = id_ex.mem_read && id_ex.rd != 5'd0 && (id_ex.rd == rs1 || id_ex.rd == rs2);
  assign flush = is_beq && (rd1 == rd2) && !stall;

  // EX operand forwarding, EX/MEM before MEM/WB
  always_comb begin
    fwd_a = id_ex.a;
    fwd_b = id_ex.b;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1) fwd_a = ex_mem.alu_res;
    else if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1) fwd_a = mem_wb.wb_data;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2) fwd_b = ex_mem.alu_res;
    else if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2) fwd_b = mem_wb.wb_data;
    op_b = id_ex.use_imm ? id_ex.imm : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (id_ex.alu_op)
      ALU_ADD: alu_res = fwd_a + op_b;
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_XOR: alu_res = fwd_a ^ op_b;
      ALU_SLL: alu_res = fwd_a << op_b[4:0];
      ALU_SRA: alu_res = 32'($signed(fwd_a) >>> op_b[4:0]);
      ALU_MUL: alu_res = 32'(fwd_a * op_b);
      default: alu_res = '0;
    endcase
  end

  assign mem_rdata = data_mem[ex_mem.alu_res[DA_W+1:2]];
  assign wb_data   = mem_wb.wb_data;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      if (start_i && !stall) pc <= flush ? target : pc + 32'd4;
      if (!stall) begin
        if (flush || !start_i) if_id <= '0;
        else                   if_id <= '{pc: pc, instr: instr_mem[pc[IA_W+1:2]]};
      end
      id_ex  <= stall ? '0 : dec;
      ex_mem <= '{reg_write: id_ex.reg_write, mem_read: id_ex.mem_read,
                  mem_write: id_ex.mem_write, rd: id_ex.rd,
                  alu_res: alu_res, store_data: fwd_b};
      mem_wb <= '{reg_write: ex_mem.reg_write, rd: ex_mem.rd,
                  wb_data: ex_mem.mem_read ? mem_rdata : ex_mem.alu_res};
    end
  end

  // Architectural state survives reset; in-flight writes are dropped
  always_ff @(posedge clk_i) begin
    if (rst_i && mem_wb.reg_write && mem_wb.rd != 5'd0) regfile[mem_wb.rd] <= mem_wb.wb_data;
    if (rst_i && ex_mem.mem_write) data_mem[ex_mem.alu_res[DA_W+1:2]] <= ex_mem.store_data;
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (start_i && stall) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (start_i && flush) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_pipe_cpu.sv
// Directed self-checking bench for riscv_pipe_cpu: programs preloaded through hierarchy.
module tb_riscv_pipe_cpu;

  logic clk = 1'b0;
  logic rst_i;
  logic start_i;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned stall_seen, flush_seen, hold_seen;
  logic [31:0] prev_pc;
  logic [31:0] prog[$];

  riscv_pipe_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  // Enter reset at the next falling edge and let one rising edge pass
  task automatic hold_reset();
    @(negedge clk);
    rst_i   = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.instr_mem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.instr_mem[i] = prog[i];
    prog.delete();
  endtask

  task automatic clr_regs();
    for (int i = 0; i < 32; i++) dut.regfile[i] = 32'h0;
  endtask

  task automatic release_run();
    rst_i      = 1'b1;
    start_i    = 1'b1;
    prev_pc    = dut.pc;
    stall_seen = 0;
    flush_seen = 0;
    hold_seen  = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      stall_seen += 32'(dut.stall);
      flush_seen += 32'(dut.flush);
      if (start_i && dut.pc == prev_pc) hold_seen++;
      prev_pc = dut.pc;
    end
  endtask

  initial begin
    rst_i   = 1'b0;
    start_i = 1'b0;

    // Reset state
    hold_reset();
    chk("rst_pc", dut.pc, 32'h0);
    chk("rst_ifid", dut.if_id.instr, 32'h0);
    chk("rst_idex", {31'b0, |dut.id_ex}, 32'h0);
    chk("rst_exmem", {31'b0, |dut.ex_mem}, 32'h0);
    chk("rst_memwb", {31'b0, |dut.mem_wb}, 32'h0);

    // Back-to-back EX/MEM forward and 5-edge write latency
    prog.push_back(addi(5'd1, 5'd0, 12'd10));
    prog.push_back(enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2));
    load_prog();
    clr_regs();
    release_run();
    run(4);
    chk("lat_before", dut.regfile[1], 32'h0);
    run(1);
    chk("lat_at5", dut.regfile[1], 32'd10);
    run(8);
    chk("fwd_x2", dut.regfile[2], 32'd20);
    chk("fwd_nostall", stall_seen, 32'd0);

    // Load-use: one bubble, one PC hold
    hold_reset();
    prog.push_back(lw(5'd1, 5'd0, 12'd0));
    prog.push_back(addi(5'd2, 5'd1, 12'd3));
    load_prog();
    clr_regs();
    dut.data_mem[0] = 32'd5;
    release_run();
    run(12);
    chk("lu_x1", dut.regfile[1], 32'd5);
    chk("lu_x2", dut.regfile[2], 32'd8);
    chk("lu_stalls", stall_seen, 32'd1);
    chk("lu_pchold", hold_seen, 32'd1);

    // Taken beq flushes one slot; later not-taken beq falls through
    hold_reset();
    prog.push_back(addi(5'd1, 5'd0, 12'd1));
    prog.push_back(32'h0);
    prog.push_back(32'h0);
    prog.push_back(32'h0);
    prog.push_back(beq(5'd1, 5'd1, 13'd8));
    prog.push_back(addi(5'd3, 5'd0, 12'd7));
    prog.push_back(addi(5'd4, 5'd0, 12'd9));
    prog.push_back(beq(5'd1, 5'd0, 13'd8));
    prog.push_back(addi(5'd5, 5'd0, 12'd5));
    load_prog();
    clr_regs();
    release_run();
    run(20);
    chk("br_flushes", flush_seen, 32'd1);
    chk("br_x3", dut.regfile[3], 32'h0);
    chk("br_x4", dut.regfile[4], 32'd9);
    chk("br_x5_nt", dut.regfile[5], 32'd5);
    chk("br_nostall", stall_seen, 32'd0);

    // Store with forwarded data, then load it back
    hold_reset();
    prog.push_back(addi(5'd5, 5'd0, 12'hFFD));
    prog.push_back(sw(5'd5, 5'd0, 12'd4));
    prog.push_back(lw(5'd6, 5'd0, 12'd4));
    load_prog();
    clr_regs();
    dut.data_mem[1] = 32'h0;
    release_run();
    run(12);
    chk("sw_mem1", dut.data_mem[1], 32'hFFFF_FFFD);
    chk("lw_x6", dut.regfile[6], 32'hFFFF_FFFD);

    // ALU ops, forwarding priority, x0, illegal encodings, start_i pause
    hold_reset();
    prog.push_back(addi(5'd1, 5'd0, 12'hFF0));
    prog.push_back({7'b0100000, 5'd2, 5'd1, 3'b101, 5'd2, 7'b0010011});
    prog.push_back(enc_r(7'b0000001, 5'd1, 5'd1, 3'b000, 5'd3));
    prog.push_back(enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd4));
    prog.push_back(enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd5));
    prog.push_back(enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd6));
    prog.push_back(addi(5'd8, 5'd0, 12'd3));
    prog.push_back(enc_r(7'b0000000, 5'd1, 5'd8, 3'b001, 5'd9));
    prog.push_back(enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd10));
    prog.push_back(addi(5'd11, 5'd0, 12'd1));
    prog.push_back(addi(5'd11, 5'd0, 12'd2));
    prog.push_back(enc_r(7'b0000000, 5'd0, 5'd11, 3'b000, 5'd12));
    prog.push_back(addi(5'd0, 5'd0, 12'd5));
    prog.push_back(enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd13));
    prog.push_back(enc_r(7'b0000010, 5'd1, 5'd1, 3'b000, 5'd14));
    prog.push_back(32'hFFFF_FFFF);
    prog.push_back(enc_r(7'b0000000, 5'd8, 5'd8, 3'b001, 5'd7));
    load_prog();
    clr_regs();
    dut.regfile[14] = 32'h55;
    dut.regfile[31] = 32'h66;
    release_run();
    run(5);
    start_i = 1'b0;
    prev_pc = dut.pc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_pc", dut.pc, prev_pc);
    end
    start_i = 1'b1;
    run(30);
    chk("alu_srai", dut.regfile[2], 32'hFFFF_FFFC);
    chk("alu_mul", dut.regfile[3], 32'd256);
    chk("alu_sub", dut.regfile[4], 32'd12);
    chk("alu_xor", dut.regfile[5], 32'h0000_000C);
    chk("alu_and", dut.regfile[6], 32'hFFFF_FFF0);
    chk("alu_sll_rs2lo", dut.regfile[9], 32'h0003_0000);
    chk("alu_neg", dut.regfile[10], 32'd16);
    chk("fwd_prio", dut.regfile[12], 32'd2);
    chk("x0_zero", dut.regfile[13], 32'h0);
    chk("illegal_f7", dut.regfile[14], 32'h55);
    chk("illegal_op", dut.regfile[31], 32'h66);
    chk("alu_sll", dut.regfile[7], 32'd24);

    // Reset mid-run clears the pipeline but keeps the register file
    release_run();
    run(3);
    rst_i = 1'b0;
    @(negedge clk);
    chk("mid_pc", dut.pc, 32'h0);
    chk("mid_ifid", dut.if_id.instr, 32'h0);
    chk("mid_idex", {31'b0, |dut.id_ex}, 32'h0);
    chk("mid_exmem", {31'b0, |dut.ex_mem}, 32'h0);
    chk("mid_memwb", {31'b0, |dut.mem_wb}, 32'h0);
    chk("mid_keep_x3", dut.regfile[3], 32'd256);
    chk("mid_keep_x9", dut.regfile[9], 32'h0003_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_pipe_cpu.md
Name: riscv_pipe_cpu

Overview:
- 5-stage in-order pipelined RV32 integer core (IF, ID, EX, MEM, WB) with internal instruction memory, data memory and register file.
- Top-level processor block. The only pins are clock, reset and start.
- Provides full EX forwarding, a one-bubble load-use stall, and branch resolution in ID with a one-slot IF flush.
- The bench preloads the memories and register file through hierarchy.

Parameters:
- IMEM_WORDS, 256: instruction memory depth in 32-bit words.
- DMEM_WORDS, 32: data memory depth in 32-bit words.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- start_i  in  1  run enable; PC advances only while start_i=1.

Behaviour:
- Internal arrays, each accessible hierarchically for preload and inspection:
  - instr_mem[IMEM_WORDS]
  - data_mem[DMEM_WORDS]
  - regfile[32]
- Memory indexing:
  - Fetch reads instr_mem[pc>>2].
  - Data memory is word-addressed by addr>>2. Read is combinational; write is on the clock edge.
- Reset (rst_i=0 at an edge) clears PC and every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) to 0. This turns every stage into a NOP.
  - regfile and the memories are NOT cleared.
  - Reset mid-run discards all in-flight instructions, and fetch restarts at PC 0.
- start_i=0: PC holds. The pipeline still clocks, so in-flight instructions drain.
- Supported ISA (funct7/funct3/opcode):
  - and 0000000/111/0110011
  - xor 0000000/100/0110011
  - sll 0000000/001/0110011
  - add 0000000/000/0110011
  - sub 0100000/000/0110011
  - mul 0000001/000/0110011 (low 32 bits)
  - addi ---/000/0010011
  - srai 0100000/101/0010011 (shamt = imm[4:0], arithmetic shift)
  - lw ---/010/0000011
  - sw ---/010/0100011
  - beq ---/000/1100011
- Unsupported encodings: any other opcode, including the all-zero word, decodes as a NOP with all controls deasserted.
- Immediates are sign-extended to 32 bits.
  - sll shifts by rs2[4:0].
  - Branch target = PC of the beq in ID + (B-imm << 1).
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Write-through: an ID read of the register being written in WB that cycle returns the new value.
- Forwarding to EX ALU operands:
  - Source is EX/MEM when its RegWrite=1, rd≠0 and rd==rs. Otherwise MEM/WB under the same conditions.
  - EX/MEM has priority.
  - sw store data uses the forwarded rs2.
- Load-use hazard:
  - Condition: ID/EX.MemRead=1 and ID/EX.rd≠0 and rd matches the ID rs1 or rs2.
  - Action: PC and IF/ID hold; a bubble (all controls zero) is written into ID/EX.
  - Exactly one stall cycle.
- Branch:
  - beq compares regfile read data in ID. There is no forwarding into ID; software inserts NOPs.
  - If taken and not stalling: PC<=target and IF/ID is flushed to instruction 0 (NOP). That is one flush cycle.
  - Not taken: PC<=PC+4.
- Simultaneous stall and branch in ID: the stall wins. The branch is not taken that cycle and is re-evaluated the next cycle.
- Internal observable nets:
  - stall: the hazard-unit output.
  - flush: the taken-branch flush.
  - Both are combinational, one per cycle.
- Latency: an ALU result is written to regfile at the 5th edge after fetch.

Optional Feature:
- PERF_CNT_EN defined:
  - Adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - Each is incremented at every edge where stall resp. flush is 1 and start_i=1.
  - Both cleared by reset.
- Undefined: the ports and counters are absent, and the core behaviour is identical.

Test Plan:
- Reset then start_i=1, program addi x1,x0,10; add x2,x1,x1 (back-to-back, EX/MEM forward) -> x1=10, x2=20, no stall.
- data_mem[0]=5; lw x1,0(x0); addi x2,x1,3 -> exactly one stall, x2=8, PC held one cycle.
- addi x1,x0,1; 3 NOPs; beq x1,x1,+8; addi x3,x0,7; addi x4,x0,9 -> one flush, x3=0, x4=9.
- sw then lw: addi x5,x0,-3; sw x5,4(x0); lw x6,4(x0) -> data_mem[1]=0xFFFFFFFD, x6=-3.
- mul/sub/xor/and/sll/srai: x1=-16, srai x2,x1,2 -> -4; mul x3,x1,x1 -> 256.
- Hold start_i=0 for 3 cycles -> PC constant. Assert rst_i=0 mid-run -> PC=0 and pipeline registers zero next edge, regfile retained.
